reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- Parametrised successor to the 8x16 single-write register file.
- Adds configurable data width and depth, async active-low reset, an optional hardwired zero register, and write-to-read bypass.
- Adds a per-register busy scoreboard so the decode stage can detect RAW hazards against in-flight writebacks.
- Sits between decode (read ports, busy set) and writeback (write port, busy clear).

Parameters:
DATA_W, 16, register data width in bits
ADDR_W, 3, register index width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to matching read port

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
RS_ID  in  ADDR_W  read port 1 index
RT_ID  in  ADDR_W  read port 2 index
Reg_RData1  out  DATA_W  read data for RS_ID (combinational)
Reg_RData2  out  DATA_W  read data for RT_ID (combinational)
Reg_Write  in  1  writeback enable
Reg_W_ID  in  ADDR_W  writeback index
Reg_WData  in  DATA_W  writeback data
Busy_Set  in  1  issue of an instruction that will write Busy_ID
Busy_ID  in  ADDR_W  destination index being issued
RS_Busy  out  1  RS_ID has a pending write (after same-cycle clear)
RT_Busy  out  1  RT_ID has a pending write (after same-cycle clear)
Hazard  out  1  RS_Busy OR RT_Busy
Busy_Vec  out  2**ADDR_W  raw scoreboard state, for debug

Behaviour:
- Reset (RST_N low, asynchronous): all registers = 0, all busy bits = 0. Reg_RData1/2 read 0; RS_Busy, RT_Busy, Hazard = 0.
- Reset release: takes effect at the next CLK edge; no sync stage inside the block.
- Reads: combinational from array, zero latency.
  - BYPASS=1 and Reg_Write=1 and Reg_W_ID==RS_ID: Reg_RData1 = Reg_WData. Same rule for RT_ID / Reg_RData2.
  - BYPASS=0: read returns the old value until the next edge.
- Write: on rising edge, if Reg_Write, reg[Reg_W_ID] <= Reg_WData. Otherwise hold.
- Zero register (ZERO_REG=1):
  - Index 0 always reads 0; bypass never applies to it.
  - Writes to index 0 are discarded.
  - Busy_Set to index 0 is ignored; RS/RT_Busy for index 0 are always 0.
- Scoreboard, one bit per register, updated on rising edge:
  - Reg_Write clears busy[Reg_W_ID].
  - Busy_Set sets busy[Busy_ID].
  - Same index cleared and set in the same cycle: set wins (new producer supersedes the retiring one).
  - Different indices: both updates apply.
  - Busy_Set on an already-busy register: stays busy; no counting.
  - Reg_Write to a non-busy register: write still happens; busy stays 0.
- Busy outputs (combinational):
  - RS_Busy = busy[RS_ID] AND NOT (Reg_Write AND Reg_W_ID==RS_ID). The retiring write forwards the value this cycle, with BYPASS=1 only.
  - With BYPASS=0 the same-cycle clear is NOT masked: RS_Busy = busy[RS_ID].
  - RT_Busy follows the same rules against RT_ID.
  - Busy_Set in the current cycle does not affect this cycle's busy outputs.
- Widths:
  - No arithmetic; data is passed through unmodified.
  - Indices are used in full; depth is always a power of two, so there are no out-of-range cases.
- Reset mid-operation: pending busy bits are lost; the pipeline must be flushed together with this block.

Decomposition:
- Shared package cpu_pkg holds DATA_W/ADDR_W defaults and the reg-index typedef, reused by decode and writeback.
- One natural sub-module: reg_scoreboard (busy vector; set/clear priority; masked busy outputs).
- The data array and bypass mux stay in the top module.

Test Plan:
- Reset: drive RST_N=0 mid-cycle -> all reads 0 immediately, Busy_Vec=0; after release, reg3 reads 0.
- Write/read: write 16'h1234 to reg5, next cycle RS_ID=5 -> Reg_RData1=16'h1234. Write 16'hBEEF to reg0 with ZERO_REG=1 -> reads 0.
- Bypass: Reg_Write=1, Reg_W_ID=2, Reg_WData=16'hA5A5, RT_ID=2 in the same cycle -> Reg_RData2=16'hA5A5 with BYPASS=1. With BYPASS=0 -> old value, then 16'hA5A5 next cycle.
- Scoreboard hazard: Busy_Set reg4; next cycle RS_ID=4 -> RS_Busy=1, Hazard=1. Reg_Write reg4 -> RS_Busy=0 in that cycle (BYPASS=1); Busy_Vec[4]=0 after the edge.
- Set/clear collision: busy[6]=1, same cycle Reg_Write reg6 and Busy_Set reg6 -> Busy_Vec[6]=1 after the edge. Different indices 1/7 -> busy[1] set and busy[7] cleared.
- Parameter sweep: DATA_W=32, ADDR_W=5 -> write/read all 32 registers with walking-ones data; busy vector is 32 bits and all bits set/clear correctly.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU-wide defaults for the register file, decode and writeback
// stages: default data/index widths and the register index/data typedefs.
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_DATA_W = 16;
    localparam int CPU_ADDR_W = 3;
    localparam int CPU_DEPTH  = 1 << CPU_ADDR_W;

    typedef logic [CPU_ADDR_W-1:0] reg_id_t;
    typedef logic [CPU_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_scoreboard
// One busy bit per architectural register. A bit is set when decode issues
// an instruction that will write that register and cleared when writeback
// retires the write. Busy outputs for the two read indices are combinational.
//
// Ports:
//   i_clk        clock, state updates on rising edge
//   i_rst_n      asynchronous active-low reset (clears all busy bits)
//   i_wr_en      writeback enable (clear request)
//   i_wr_id      writeback index
//   i_set_en     issue of a producer (set request)
//   i_set_id     producer destination index
//   i_rs_id      read port 1 index
//   i_rt_id      read port 2 index
//   o_rs_busy    busy[rs] after same-cycle retire masking (BYPASS only)
//   o_rt_busy    busy[rt] after same-cycle retire masking (BYPASS only)
//   o_hazard     o_rs_busy | o_rt_busy
//   o_busy_vec   raw scoreboard state
// ----------------------------------------------------------------------------
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wr_en,
    input  logic [ADDR_W-1:0]      i_wr_id,
    input  logic                   i_set_en,
    input  logic [ADDR_W-1:0]      i_set_id,
    input  logic [ADDR_W-1:0]      i_rs_id,
    input  logic [ADDR_W-1:0]      i_rt_id,
    output logic                   o_rs_busy,
    output logic                   o_rt_busy,
    output logic                   o_hazard,
    output logic [(1<<ADDR_W)-1:0] o_busy_vec
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;
    logic             w_rs_retire;
    logic             w_rt_retire;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_busy
            // The hardwired zero register never has a producer in flight.
            localparam bit IS_ZERO = ZERO_REG && (gi == 0);

            logic w_set;
            logic w_clr;

            assign w_set = !IS_ZERO && i_set_en && (i_set_id == ADDR_W'(gi));
            assign w_clr = i_wr_en && (i_wr_id == ADDR_W'(gi));

            // Set beats clear: a newly issued producer supersedes the one
            // retiring in the same cycle.
            assign w_busy_next[gi] = w_set ? 1'b1 :
                                     w_clr ? 1'b0 : r_busy[gi];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // With bypass, a retiring write forwards its data this cycle, so the
    // consumer need not stall; without bypass it must wait for the edge.
    assign w_rs_retire = BYPASS && i_wr_en && (i_wr_id == i_rs_id);
    assign w_rt_retire = BYPASS && i_wr_en && (i_wr_id == i_rt_id);

    assign o_rs_busy  = r_busy[i_rs_id] && !w_rs_retire;
    assign o_rt_busy  = r_busy[i_rt_id] && !w_rt_retire;
    assign o_hazard   = o_rs_busy || o_rt_busy;
    assign o_busy_vec = r_busy;

endmodule

// File: rtl/reg_file_sb.sv
// ----------------------------------------------------------------------------
// reg_file_sb
// Parametrised 2-read / 1-write register file with optional hardwired zero
// register, optional write-to-read bypass and a per-register busy scoreboard
// for RAW hazard detection between decode and writeback.
//
// Ports:
//   CLK          clock, all state updates on rising edge
//   RST_N        asynchronous active-low reset
//   RS_ID/RT_ID  read indices; Reg_RData1/Reg_RData2 combinational read data
//   Reg_Write    writeback enable, Reg_W_ID index, Reg_WData data
//   Busy_Set     issue of a producer for Busy_ID
//   RS_Busy/RT_Busy  pending write on the read index (retire-masked w/ bypass)
//   Hazard       RS_Busy | RT_Busy
//   Busy_Vec     raw scoreboard state
// ----------------------------------------------------------------------------
module reg_file_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [ADDR_W-1:0]      RS_ID,
    input  logic [ADDR_W-1:0]      RT_ID,
    output logic [DATA_W-1:0]      Reg_RData1,
    output logic [DATA_W-1:0]      Reg_RData2,
    input  logic                   Reg_Write,
    input  logic [ADDR_W-1:0]      Reg_W_ID,
    input  logic [DATA_W-1:0]      Reg_WData,
    input  logic                   Busy_Set,
    input  logic [ADDR_W-1:0]      Busy_ID,
    output logic                   RS_Busy,
    output logic                   RT_Busy,
    output logic                   Hazard,
    output logic [(1<<ADDR_W)-1:0] Busy_Vec
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              w_wr_en;
    logic              w_rs_zero;
    logic              w_rt_zero;
    logic              w_rs_fwd;
    logic              w_rt_fwd;

    assign w_rs_zero = ZERO_REG && (RS_ID == '0);
    assign w_rt_zero = ZERO_REG && (RT_ID == '0);

    // Writes to the hardwired zero register are dropped at the array.
    assign w_wr_en = Reg_Write && !(ZERO_REG && (Reg_W_ID == '0));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[Reg_W_ID] <= Reg_WData;
        end
    end

    assign w_rs_fwd = BYPASS && Reg_Write && (Reg_W_ID == RS_ID);
    assign w_rt_fwd = BYPASS && Reg_Write && (Reg_W_ID == RT_ID);

    // Zero register takes priority over the bypass path.
    always_comb begin
        Reg_RData1 = r_regs[RS_ID];
        if (w_rs_zero) begin
            Reg_RData1 = '0;
        end else if (w_rs_fwd) begin
            Reg_RData1 = Reg_WData;
        end
    end

    always_comb begin
        Reg_RData2 = r_regs[RT_ID];
        if (w_rt_zero) begin
            Reg_RData2 = '0;
        end else if (w_rt_fwd) begin
            Reg_RData2 = Reg_WData;
        end
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .i_clk      (CLK),
        .i_rst_n    (RST_N),
        .i_wr_en    (Reg_Write),
        .i_wr_id    (Reg_W_ID),
        .i_set_en   (Busy_Set),
        .i_set_id   (Busy_ID),
        .i_rs_id    (RS_ID),
        .i_rt_id    (RT_ID),
        .o_rs_busy  (RS_Busy),
        .o_rt_busy  (RT_Busy),
        .o_hazard   (Hazard),
        .o_busy_vec (Busy_Vec)
    );

endmodule
